// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video memory between the display
// fetch path, host reads and a small queue of posted host writes.
// One access slot per cycle, fixed priority display > host read > host write.
module vram_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_data,
  input  logic          host_wr_valid,
  output logic          host_wr_ready,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [DW-1:0] host_wr_data,
  input  logic          host_rd_valid,
  output logic          host_rd_ready,
  input  logic [AW-1:0] host_rd_addr,
  output logic          host_rd_done,
  output logic [DW-1:0] host_rd_data,
  output logic [LW-1:0] fifo_level,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Goes high on the first edge after reset release; gates every slot so
  // nothing touches memory while reset is held.
  logic          active_reg;
  logic          wr_ready_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic          disp_valid_reg;
  logic          rd_done_reg;
  logic [AW-1:0] hold_addr_reg;
  logic [DW-1:0] hold_din_reg;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];

  logic disp_slot;
  logic rd_slot;
  logic wr_slot;
  logic push;

  // Slot arbitration: a read is only offered when the write queue is empty,
  // so it can never overtake a queued write.
  assign host_rd_ready = active_reg & host_rd_valid & ~disp_req & (level_reg == '0);
  assign host_wr_ready = wr_ready_reg;
  assign fifo_level    = level_reg;
  assign disp_valid    = disp_valid_reg;
  assign host_rd_done  = rd_done_reg;
  assign disp_data     = disp_valid_reg ? mem_dout : '0;
  assign host_rd_data  = rd_done_reg ? mem_dout : '0;
  assign push          = host_wr_valid & wr_ready_reg;

  // Pick the single memory user for this cycle.
  always_comb begin
    disp_slot = active_reg & disp_req;
    rd_slot   = host_rd_valid & host_rd_ready;
    wr_slot   = active_reg & ~disp_req & ~rd_slot & (level_reg != '0);
  end

  // Drive the memory port from the winning requester; address and data hold
  // their last value when the slot is idle.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = hold_addr_reg;
    mem_din  = hold_din_reg;
    if (disp_slot) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (rd_slot) begin
      mem_en   = 1'b1;
      mem_addr = host_rd_addr;
    end else if (wr_slot) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = fifo_addr[rd_ptr_reg];
      mem_din  = fifo_data[rd_ptr_reg];
    end
  end

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    level_next = level_reg;
    if (push && !wr_slot) begin
      level_next = level_reg + LW'(1);
    end else if (!push && wr_slot) begin
      level_next = level_reg - LW'(1);
    end
  end

  // Write queue storage; contents are don't-care until pointers cover them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_reg] <= host_wr_addr;
      fifo_data[wr_ptr_reg] <= host_wr_data;
    end
  end

  // Control state: pointers, occupancy, registered ready and response strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg     <= 1'b0;
      wr_ready_reg   <= 1'b0;
      level_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      disp_valid_reg <= 1'b0;
      rd_done_reg    <= 1'b0;
      hold_addr_reg  <= '0;
      hold_din_reg   <= '0;
    end else begin
      active_reg     <= 1'b1;
      level_reg      <= level_next;
      wr_ready_reg   <= (level_next != LW'(FIFO_DEPTH));
      disp_valid_reg <= disp_slot;
      rd_done_reg    <= rd_slot;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (wr_slot) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (mem_en) begin
        hold_addr_reg <= mem_addr;
        hold_din_reg  <= mem_din;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency memory model.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int LW = $clog2(FD) + 1;

  logic          clk;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_rd_valid;
  logic          host_rd_ready;
  logic [AW-1:0] host_rd_addr;
  logic          host_rd_done;
  logic [DW-1:0] host_rd_data;
  logic [LW-1:0] fifo_level;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int total;
  int bad;

  logic [DW-1:0] vram [0:(1<<AW)-1];

  vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .host_rd_addr(host_rd_addr),
    .host_rd_done(host_rd_done), .host_rd_data(host_rd_data),
    .fifo_level(fifo_level),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port memory with registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_din;
      else        mem_dout <= vram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next mid-cycle point where inputs may change.
  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mem_dout = '0;
    for (int i = 0; i < (1 << AW); i++) vram[i] = '0;
    for (int i = 0; i < 8; i++) vram[i] = DW'(i);

    rst = 1'b1;
    disp_req = 1'b1; disp_addr = '0;
    host_wr_valid = 1'b1; host_wr_addr = '0; host_wr_data = '0;
    host_rd_valid = 1'b1; host_rd_addr = '0;

    // Reset state with every request asserted
    cyc; cyc; #1;
    check("rst_disp_valid", disp_valid, 0);
    check("rst_rd_done", host_rd_done, 0);
    check("rst_level", fifo_level, 0);
    check("rst_wr_ready", host_wr_ready, 0);
    check("rst_rd_ready", host_rd_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_rd_data", host_rd_data, 0);
    $display("reset state checked");

    cyc;
    rst = 1'b0; disp_req = 1'b0; host_wr_valid = 1'b0; host_rd_valid = 1'b0;
    cyc; #1;
    check("post_rst_wr_ready", host_wr_ready, 1);
    check("post_rst_level", fifo_level, 0);

    // Display burst over addresses 0..7
    for (int i = 0; i < 8; i++) begin
      cyc;
      disp_req = 1'b1; disp_addr = AW'(i);
      #1;
      check("burst_en", mem_en, 1);
      check("burst_we", mem_we, 0);
      check("burst_addr", mem_addr, i);
      if (i > 0) begin
        check("burst_valid", disp_valid, 1);
        check("burst_data", disp_data, i - 1);
      end
      $display("display fetch addr=%0d", i);
    end
    cyc;
    disp_req = 1'b0;
    #1;
    check("burst_last_valid", disp_valid, 1);
    check("burst_last_data", disp_data, 7);
    check("idle_en", mem_en, 0);
    check("idle_hold_addr", mem_addr, 7);
    cyc; #1;
    check("burst_end_valid", disp_valid, 0);

    // Fill the write queue while the display owns every slot
    for (int k = 0; k < 5; k++) begin
      cyc;
      disp_req = 1'b1; disp_addr = AW'(100);
      host_wr_valid = 1'b1; host_wr_addr = AW'(32 + k); host_wr_data = DW'(80 + k);
      #1;
      check("fill_level", fifo_level, (k < 4) ? k : 4);
      check("fill_ready", host_wr_ready, (k < 4) ? 1 : 0);
      check("fill_we", mem_we, 0);
      $display("host write push attempt %0d addr=0x%0h", k, 32 + k);
    end

    // Drain once the display lets go
    for (int d = 0; d < 4; d++) begin
      cyc;
      disp_req = 1'b0; host_wr_valid = 1'b0;
      #1;
      check("drain_level", fifo_level, 4 - d);
      check("drain_ready", host_wr_ready, (d == 0) ? 0 : 1);
      check("drain_we", mem_we, 1);
      check("drain_addr", mem_addr, 32 + d);
      check("drain_din", mem_din, 80 + d);
      $display("drain write %0d", d);
    end
    cyc; #1;
    check("drained_level", fifo_level, 0);
    check("drained_en", mem_en, 0);
    check("drained_ready", host_wr_ready, 1);

    // Read-after-write: the read waits for the queued write to land
    cyc;
    disp_req = 1'b1; disp_addr = AW'(5);
    host_wr_valid = 1'b1; host_wr_addr = AW'(16); host_wr_data = 8'hA5;
    host_rd_valid = 1'b1; host_rd_addr = AW'(16);
    #1;
    check("raw_rd_ready_a", host_rd_ready, 0);
    cyc;
    disp_req = 1'b0; host_wr_valid = 1'b0;
    #1;
    check("raw_rd_ready_b", host_rd_ready, 0);
    check("raw_wr_we", mem_we, 1);
    check("raw_wr_addr", mem_addr, 16);
    check("raw_wr_din", mem_din, 8'hA5);
    cyc; #1;
    check("raw_rd_ready_c", host_rd_ready, 1);
    check("raw_rd_en", mem_en, 1);
    check("raw_rd_we", mem_we, 0);
    check("raw_rd_addr", mem_addr, 16);
    cyc;
    host_rd_valid = 1'b0;
    #1;
    check("raw_done", host_rd_done, 1);
    check("raw_data", host_rd_data, 8'hA5);
    cyc; #1;
    check("raw_done_once", host_rd_done, 0);
    $display("host read-after-write addr=0x10 complete");

    // Contention: display, host read and non-empty queue together
    cyc;
    disp_req = 1'b1; disp_addr = AW'(3);
    host_wr_valid = 1'b1; host_wr_addr = AW'(48); host_wr_data = 8'h77;
    cyc;
    host_wr_valid = 1'b0;
    host_rd_valid = 1'b1; host_rd_addr = AW'(34);
    #1;
    check("cont_level", fifo_level, 1);
    check("cont_disp_addr", mem_addr, 3);
    check("cont_disp_we", mem_we, 0);
    check("cont_rd_ready", host_rd_ready, 0);
    cyc;
    disp_req = 1'b0;
    #1;
    check("cont_wr_we", mem_we, 1);
    check("cont_wr_addr", mem_addr, 48);
    check("cont_rd_ready2", host_rd_ready, 0);
    check("cont_disp_data", disp_data, 3);
    cyc; #1;
    check("cont_rd_grant", host_rd_ready, 1);
    check("cont_rd_addr", mem_addr, 34);
    cyc;
    host_rd_valid = 1'b0;
    #1;
    check("cont_rd_done", host_rd_done, 1);
    check("cont_rd_data", host_rd_data, 8'h52);
    $display("contention sequence complete");

    // Mid-operation reset with queued writes and a pending display response
    for (int k = 0; k < 3; k++) begin
      cyc;
      disp_req = 1'b1; disp_addr = AW'(1);
      host_wr_valid = 1'b1; host_wr_addr = AW'(64 + k); host_wr_data = DW'(17 + k);
    end
    cyc;
    disp_req = 1'b0; host_wr_valid = 1'b0;
    #1;
    check("pre_rst_level", fifo_level, 3);
    check("pre_rst_disp_valid", disp_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_disp_valid", disp_valid, 0);
    check("mid_rst_en", mem_en, 0);
    cyc;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc; #1;
      check("post_rst_no_we", mem_we, 0);
      check("post_rst_level0", fifo_level, 0);
    end
    check("post_rst_ready1", host_wr_ready, 1);
    $display("mid-operation reset complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, 13, memory address width.
REQ-002 Parameter DW, 8, memory data width.
REQ-003 Parameter FIFO_DEPTH, 4, host write FIFO entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 disp_req  in  1  display fetch request for the current cycle (driven from the VGA controller's data_req).
REQ-007 disp_addr  in  AW  display fetch address, valid with disp_req.
REQ-008 disp_valid  out  1  display read data valid.
REQ-009 disp_data  out  DW  display read data.
REQ-010 host_wr_valid / host_wr_ready  in / out  1 / 1  host write handshake.
REQ-011 host_wr_addr / host_wr_data  in / in  AW / DW  host write payload.
REQ-012 host_rd_valid / host_rd_ready  in / out  1 / 1  host read handshake.
REQ-013 host_rd_addr  in  AW  host read address.
REQ-014 host_rd_done / host_rd_data  out / out  1 / DW  host read response.
REQ-015 fifo_level  out  clog2(FIFO_DEPTH)+1  current host write FIFO occupancy.
REQ-016 mem_en / mem_we / mem_addr / mem_din  out  1 / 1 / AW / DW  single-port memory control.
REQ-017 mem_dout  in  DW  memory read data; one-cycle read latency.

Function
REQ-018 The block SHALL own exactly one memory access slot per cycle; the mem_* outputs SHALL be combinational from the current inputs and the FIFO head.
REQ-019 Slot priority SHALL be fixed: display, then host read, then host write.
REQ-020 Display slot: when disp_req=1, the block SHALL drive mem_en=1, mem_we=0, and mem_addr=disp_addr in the same cycle, with no stall ever.
REQ-021 disp_valid SHALL be registered and high exactly one cycle after each display slot; disp_data SHALL equal mem_dout in that cycle.
REQ-022 host_rd_ready SHALL equal host_rd_valid AND NOT disp_req AND (fifo_level==0).
REQ-023 A host read SHALL therefore never bypass a queued write, preserving read-after-write ordering.
REQ-024 Host read slot: on a host read handshake, the block SHALL drive mem_en=1, mem_we=0, and mem_addr=host_rd_addr.
REQ-025 host_rd_done SHALL be high for exactly one cycle, one cycle after the handshake; host_rd_data SHALL equal mem_dout in that cycle.
REQ-026 host_wr_ready SHALL equal NOT full, where full means fifo_level==FIFO_DEPTH, and SHALL be derived from registered state only.
REQ-027 A push SHALL occur on host_wr_valid AND host_wr_ready.
REQ-028 There SHALL be no bypass path: a pushed write reaches memory no earlier than the next cycle.
REQ-029 Write slot: when disp_req=0, no host read handshake occurs, and fifo_level>0, the block SHALL drive mem_en=1, mem_we=1, and addr/din from the FIFO head, then pop.
REQ-030 Writes SHALL drain in push order.
REQ-031 A push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-032 A push when fifo_level==FIFO_DEPTH-1 with no pop SHALL make the FIFO full; host_wr_ready SHALL drop the next cycle.
REQ-033 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL never exceed FIFO_DEPTH or underflow below 0.
REQ-034 Under continuous disp_req, host traffic SHALL stall indefinitely, with no timeout and no data loss.
REQ-035 When no slot is used, mem_en=0, mem_we=0, and mem_addr/mem_din SHALL hold their previous value.

Reset
REQ-036 While rst=1: disp_valid=0, host_rd_done=0, fifo_level=0, host_wr_ready=0, host_rd_ready=0, mem_en=0, mem_we=0, disp_data=0, host_rd_data=0, and pointers=0.
REQ-037 Reset asserted mid-operation SHALL discard queued writes and in-flight read responses; no partial write SHALL be issued after release.
REQ-038 On the first clock edge after rst deasserts, host_wr_ready SHALL be 1.

Verification
REQ-039 Display burst: disp_req=1 for 8 cycles, addr 0..7, memory preloaded with value = addr -> disp_valid for 8 cycles starting 1 cycle later, disp_data 0..7, no mem_we during the burst.
REQ-040 Write fill under display: disp_req=1 continuously; push 5 writes -> fifo_level reaches 4, host_wr_ready=0 on the 5th, mem_we never asserted.
REQ-041 Write drain: release disp_req -> 4 consecutive write slots, in order -> fifo_level 4,3,2,1,0 -> host_wr_ready back to 1.
REQ-042 Read-after-write: push write addr 0x10 = 0xA5, assert host read 0x10 in the same cycle -> host_rd_ready=0 until the write drains -> host_rd_done with data 0xA5.
REQ-043 Contention: disp_req, host_rd_valid, and a non-empty FIFO all high in one cycle -> only the display is served; the read is granted on the first cycle where disp_req=0 and the FIFO is empty.
REQ-044 Mid-operation reset: 3 writes queued plus a pending display response, then pulse rst -> fifo_level=0, disp_valid=0, and no mem_we after release.
